pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed ID/EX latch. It is a generic pipeline stage register carrying an opaque DATA_W payload between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, an optional 2-entry skid buffer that breaks the ready path, synchronous flush (bubble insertion) and a sticky halt lock.
- The datapath packs its stage signals into in_data and unpacks them from out_data.

---
 rtl/pipe_stage_skid.sv | 189 ++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic valid/ready pipeline stage register carrying an
// opaque DATA_W payload between two CPU stages. SKID=1 gives a 2-entry skid
// buffer with a registered in_ready; SKID=0 gives a single entry with a
// combinational in_ready. Supports flush (bubble insertion) and a sticky
// halt lock.
// Optional feature: define PIPE_STATS_EN to add the saturating stall_cnt and
// flush_cnt statistics counters.
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halt_lock
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Bit 0 of the state is "head valid", so out_valid comes straight from a flop.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [DATA_W-1:0] head_data_r, head_data_nxt_s;
  logic [DATA_W-1:0] skid_data_r, skid_data_nxt_s;
  logic              head_halt_r, head_halt_nxt_s;
  logic              skid_halt_r, skid_halt_nxt_s;
  logic              lock_r, lock_nxt_s;
  logic              ready_r;
  logic              accept_s, emit_s, halt_pending_s;

  assign accept_s = in_valid && in_ready;
  assign emit_s   = out_valid && out_ready;

  // A halt beat that is still held once this cycle's emit completes; a flush
  // squashes it, so the lock belonged to a mispredicted path.
  assign halt_pending_s = ((state_r == TWO) && skid_halt_r) ||
                          ((state_r != EMPTY) && head_halt_r && !out_ready);

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ready_r;
    end else begin : g_noskid
      assign in_ready = ((state_r == EMPTY) || out_ready) && !lock_r;
    end
  endgenerate

  // Next-state: flush squashes everything, otherwise fill/drain head and skid
  always_comb begin
    state_nxt_s     = state_r;
    head_data_nxt_s = head_data_r;
    head_halt_nxt_s = head_halt_r;
    skid_data_nxt_s = skid_data_r;
    skid_halt_nxt_s = skid_halt_r;
    lock_nxt_s      = lock_r;
    if (flush) begin
      state_nxt_s     = EMPTY;
      head_data_nxt_s = {DATA_W{1'b0}};
      head_halt_nxt_s = 1'b0;
      skid_data_nxt_s = {DATA_W{1'b0}};
      skid_halt_nxt_s = 1'b0;
      lock_nxt_s      = lock_r && !halt_pending_s;
    end else begin
      if (accept_s && in_halt) begin
        lock_nxt_s = 1'b1;
      end else begin
        lock_nxt_s = lock_r;
      end
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nxt_s     = ONE;
            head_data_nxt_s = in_data;
            head_halt_nxt_s = in_halt;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (emit_s && accept_s) begin
            head_data_nxt_s = in_data;
            head_halt_nxt_s = in_halt;
          end else if (emit_s) begin
            state_nxt_s     = EMPTY;
            head_data_nxt_s = {DATA_W{1'b0}};
            head_halt_nxt_s = 1'b0;
          end else if (accept_s && (SKID != 0)) begin
            state_nxt_s     = TWO;
            skid_data_nxt_s = in_data;
            skid_halt_nxt_s = in_halt;
          end else begin
            state_nxt_s = ONE;
          end
        end
        TWO: begin
          if (emit_s) begin
            state_nxt_s     = ONE;
            head_data_nxt_s = skid_data_r;
            head_halt_nxt_s = skid_halt_r;
            skid_data_nxt_s = {DATA_W{1'b0}};
            skid_halt_nxt_s = 1'b0;
          end else begin
            state_nxt_s = TWO;
          end
        end
        default: begin
          state_nxt_s     = EMPTY;
          head_data_nxt_s = {DATA_W{1'b0}};
          head_halt_nxt_s = 1'b0;
          skid_data_nxt_s = {DATA_W{1'b0}};
          skid_halt_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Stage registers; in_ready is precomputed from the next state so it is a flop
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= EMPTY;
      head_data_r <= {DATA_W{1'b0}};
      head_halt_r <= 1'b0;
      skid_data_r <= {DATA_W{1'b0}};
      skid_halt_r <= 1'b0;
      lock_r      <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      head_data_r <= head_data_nxt_s;
      head_halt_r <= head_halt_nxt_s;
      skid_data_r <= skid_data_nxt_s;
      skid_halt_r <= skid_halt_nxt_s;
      lock_r      <= lock_nxt_s;
      ready_r     <= (state_nxt_s != TWO) && !lock_nxt_s;
    end
  end

  // Head data is kept at zero whenever the head is empty, giving a NOP bubble.
  assign out_valid = state_r[0];
  assign out_data  = head_data_r;
  assign out_halt  = head_halt_r;
  assign halt_lock = lock_r;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Saturating statistics counters, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (out_valid && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  logic [CNT_W-1:0] stats_unused_s;
  assign stats_unused_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid (SKID=1): directed vector table, counter
// saturation sequence (PIPE_STATS_EN) and randomized traffic checked against
// a queue-based reference model.
`timescale 1ns/1ps
module tb_pipe_stage_skid;
  localparam int DW  = 16;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_halt, flush;
  logic          out_valid, out_ready, out_halt, halt_lock;
  logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STATS_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) dut (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
    .halt_lock(halt_lock)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model: FIFO of held beats, capacity 2 -------
  typedef struct { logic [DW-1:0] d; logic h; } beat_t;
  beat_t mq[$];
  logic  m_lock     = 1'b0;
  logic  m_rdy_zero = 1'b1;
  int    m_stall    = 0;
  int    m_flush    = 0;

  function automatic logic m_ready();
    return !m_rdy_zero && (mq.size() < 2) && !m_lock;
  endfunction

  task automatic m_step(input logic r, iv, input logic [DW-1:0] d, input logic h, f, ordy);
    logic acc, emt;
    acc = iv && m_ready();
    emt = (mq.size() > 0) && ordy;
    if (r) begin
      mq.delete(); m_lock = 1'b0; m_rdy_zero = 1'b1; m_stall = 0; m_flush = 0;
      return;
    end
    m_rdy_zero = 1'b0;
    if ((mq.size() > 0) && !ordy && (m_stall < SAT)) m_stall++;
    if (f && (m_flush < SAT)) m_flush++;
    if (emt) void'(mq.pop_front());
    if (f) begin
      foreach (mq[i]) if (mq[i].h) m_lock = 1'b0;
      mq.delete();
    end else if (acc) begin
      mq.push_back('{d, h});
      if (h) m_lock = 1'b1;
    end
  endtask

  task automatic cycle(input logic r, iv, input logic [DW-1:0] d, input logic h, f, ordy);
    rst = r; in_valid = iv; in_data = d; in_halt = h; flush = f; out_ready = ordy;
    @(posedge clk);
    m_step(r, iv, d, h, f, ordy);
    #1;
  endtask

  task automatic check_model();
    check("rnd_in_ready", in_ready, m_ready());
    check("rnd_out_valid", out_valid, mq.size() > 0);
    check("rnd_out_data", out_data, (mq.size() > 0) ? mq[0].d : 16'h0000);
    check("rnd_out_halt", out_halt, (mq.size() > 0) ? mq[0].h : 1'b0);
    check("rnd_halt_lock", halt_lock, m_lock);
`ifdef PIPE_STATS_EN
    check("rnd_stall_cnt", stall_cnt, m_stall);
    check("rnd_flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic rst, iv, ih, fl, ordy;
    logic [DW-1:0] d;
    logic ov, oh, ir, hl;
    logic [DW-1:0] od;
  } vec_t;

  // c = {rst, in_valid, in_halt, flush, out_ready}; e = {out_valid, out_halt, in_ready, halt_lock}
  function automatic vec_t v(input logic [4:0] c, input logic [DW-1:0] d,
                             input logic [3:0] e, input logic [DW-1:0] od);
    vec_t t;
    t.rst = c[4]; t.iv = c[3]; t.ih = c[2]; t.fl = c[1]; t.ordy = c[0]; t.d = d;
    t.ov = e[3]; t.oh = e[2]; t.ir = e[1]; t.hl = e[0]; t.od = od;
    return t;
  endfunction

  vec_t tbl[36];

  initial begin
    logic          pend_v, pend_h, acc, r, f, o;
    logic [DW-1:0] pend_d;

    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_halt = 1'b0;
    flush = 1'b0; out_ready = 1'b0;

    // reset held 2 cycles with a beat offered, then release
    tbl[0]  = v(5'b11000, 16'h00A5, 4'b0000, 16'h0000);
    tbl[1]  = v(5'b11000, 16'h00A5, 4'b0000, 16'h0000);
    tbl[2]  = v(5'b01000, 16'h00A5, 4'b0010, 16'h0000);
    // streaming 0x01..0x08 with out_ready=1
    for (int i = 0; i < 8; i++) tbl[3 + i] = v(5'b01001, 16'(i + 1), 4'b1010, 16'(i + 1));
    tbl[11] = v(5'b00001, 16'h0000, 4'b0010, 16'h0000);
    // skid fill and drain
    tbl[12] = v(5'b01000, 16'h0011, 4'b1010, 16'h0011);
    tbl[13] = v(5'b01000, 16'h0022, 4'b1000, 16'h0011);
    tbl[14] = v(5'b01000, 16'h0033, 4'b1000, 16'h0011);
    tbl[15] = v(5'b01001, 16'h0033, 4'b1010, 16'h0022);
    tbl[16] = v(5'b01001, 16'h0033, 4'b1010, 16'h0033);
    tbl[17] = v(5'b00001, 16'h0000, 4'b0010, 16'h0000);
    // flush from TWO, then flush discarding an accepted beat
    tbl[18] = v(5'b01000, 16'h0011, 4'b1010, 16'h0011);
    tbl[19] = v(5'b01000, 16'h0022, 4'b1000, 16'h0011);
    tbl[20] = v(5'b01010, 16'h0044, 4'b0010, 16'h0000);
    tbl[21] = v(5'b01010, 16'h0044, 4'b0010, 16'h0000);
    tbl[22] = v(5'b00001, 16'h0000, 4'b0010, 16'h0000);
    // halt lock cleared by flush before emit
    tbl[23] = v(5'b01100, 16'h0055, 4'b1101, 16'h0055);
    tbl[24] = v(5'b01000, 16'h0066, 4'b1101, 16'h0055);
    tbl[25] = v(5'b00010, 16'h0000, 4'b0010, 16'h0000);
    // halt emitted, then flush: lock stays
    tbl[26] = v(5'b01100, 16'h0055, 4'b1101, 16'h0055);
    tbl[27] = v(5'b00001, 16'h0000, 4'b0001, 16'h0000);
    tbl[28] = v(5'b00010, 16'h0000, 4'b0001, 16'h0000);
    tbl[29] = v(5'b01001, 16'h0077, 4'b0001, 16'h0000);
    // reset clears lock; halt emitted in the flush cycle keeps the lock
    tbl[30] = v(5'b10000, 16'h0000, 4'b0000, 16'h0000);
    tbl[31] = v(5'b01100, 16'h0055, 4'b0010, 16'h0000);
    tbl[32] = v(5'b01100, 16'h0055, 4'b1101, 16'h0055);
    tbl[33] = v(5'b00011, 16'h0000, 4'b0001, 16'h0000);
    tbl[34] = v(5'b10000, 16'h0000, 4'b0000, 16'h0000);
    tbl[35] = v(5'b00000, 16'h0000, 4'b0010, 16'h0000);

    for (int i = 0; i < 36; i++) begin
      cycle(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ih, tbl[i].fl, tbl[i].ordy);
      check($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ov);
      check($sformatf("v%0d_out_data", i), out_data, tbl[i].od);
      check($sformatf("v%0d_out_halt", i), out_halt, tbl[i].oh);
      check($sformatf("v%0d_in_ready", i), in_ready, tbl[i].ir);
      check($sformatf("v%0d_halt_lock", i), halt_lock, tbl[i].hl);
    end

`ifdef PIPE_STATS_EN
    // counter saturation: one held beat stalled for 20 cycles, then one flush
    check("cnt_flush_after_reset", flush_cnt, 4'd0);
    cycle(1'b0, 1'b1, 16'h00AB, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      if (i == 13) check("cnt_stall_14", stall_cnt, 4'd14);
      check("cnt_hold_data", out_data, 16'h00AB);
    end
    check("cnt_stall_sat", stall_cnt, 4'd15);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("cnt_stall_sat_hold", stall_cnt, 4'd15);
    check("cnt_flush_one", flush_cnt, 4'd1);
`endif

    // randomized traffic against the reference model
    cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_model();
    pend_v = 1'b0; pend_d = 16'h0000; pend_h = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!pend_v && ($urandom_range(0, 3) != 0)) begin
        pend_v = 1'b1;
        pend_d = DW'($urandom);
        pend_h = ($urandom_range(0, 39) == 0);
      end
      r   = ($urandom_range(0, 59) == 0);
      f   = ($urandom_range(0, 15) == 0);
      o   = ($urandom_range(0, 2) != 0);
      acc = pend_v && in_ready;
      cycle(r, pend_v, pend_v ? pend_d : 16'h0000, pend_v ? pend_h : 1'b0, f, o);
      if (acc || r) pend_v = 1'b0;
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
